// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, ALU and mux selects,
// FSM state encoding and the control-word bundle produced by the output decoder.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_RS1  = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_2_reg;
        logic       instr_done;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Anything outside the supported subset is treated as illegal and traps.
    function automatic state_e decode_opcode(input logic [6:0] op);
        case (op)
            OP_RTYPE:           return S_EXEC_R;
            OP_ITYPE:           return S_EXEC_I;
            OP_LOAD, OP_STORE:  return S_ADDR;
            OP_BRANCH:          return S_BRANCH;
            OP_JAL:             return S_JUMP;
            default:            return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-path bundle between the multicycle controller (master) and the datapath/memory (slave).
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_2_reg;
    logic       instr_done;
    logic       halted;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_2_reg, instr_done, halted
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_2_reg, instr_done, halted
    );
endinterface

// File: rtl/mc_out_decoder.sv
// State-to-control decode. Everything not set for a state stays 0; mem_ready and zero only
// qualify the completion strobes of the state that is already current.
module mc_out_decoder
    import multicycle_control_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   zero_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_NONE;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.iord      = 1'b0;
                ctrl_o.alu_src_a = SRCA_PC;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
                ctrl_o.pc_src    = 1'b0;
            end
            // PC + imm computed here so BRANCH/JUMP already have the target in ALU-out.
            S_DECODE: begin
                ctrl_o.alu_src_a = SRCA_PC;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ADDR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.mem_we     = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_WB_ALU: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_2_reg  = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            S_WB_MEM: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_2_reg  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.pc_write   = zero_i;
                ctrl_o.pc_src     = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_src     = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller: Moore FSM with memory wait handshakes and a sticky
// halt on illegal opcodes. Output decode lives in mc_out_decoder.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    state_e state_q, state_d;
    logic   halted_q;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // halted rises together with the entry into TRAP and only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (state_d == S_TRAP) begin
            halted_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = decode_opcode(bus.opcode);
            S_EXEC_R: state_d = S_WB_ALU;
            S_EXEC_I: state_d = S_WB_ALU;
            S_ADDR:   state_d = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: state_d = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_WB_ALU: state_d = S_FETCH;
            S_WB_MEM: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    mc_out_decoder u_out_decoder (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .zero_i      (bus.zero),
        .ctrl_o      (ctrl)
    );

    assign bus.mem_req    = ctrl.mem_req;
    assign bus.mem_we     = ctrl.mem_we;
    assign bus.iord       = ctrl.iord;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.pc_write   = ctrl.pc_write;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_2_reg  = ctrl.mem_2_reg;
    assign bus.instr_done = ctrl.instr_done;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction streams with random
// memory wait states, scored per instruction against latency/event-count expectations.
module tb_multicycle_control;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
                     bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.mem_2_reg,
                     bus.instr_done, bus.halted});
    endfunction

    function automatic int sel_vec();
        return int'({bus.alu_src_a, bus.alu_src_b, bus.alu_op});
    endfunction

    function automatic logic [6:0] opcode_of(input int kind);
        case (kind)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_LD:    return 7'b0000011;
            K_ST:    return 7'b0100011;
            K_BR:    return 7'b1100011;
            default: return 7'b1101111;
        endcase
    endfunction

    // ALU selects {a,b,op} of the state right after DECODE, straight from the state table.
    function automatic int exec_sel(input int kind);
        case (kind)
            K_R:        return 6'b01_00_10;
            K_I:        return 6'b01_10_10;
            K_LD, K_ST: return 6'b01_10_00;
            K_BR:       return 6'b01_00_01;
            default:    return 6'b00_00_00;
        endcase
    endfunction

    // Runs one instruction starting at its first FETCH cycle. fw/mw are the wait cycles the
    // memory inserts before mem_ready for the fetch and the data access respectively.
    task automatic run_instr(input int kind, input logic z, input int fw, input int mw,
                             input string tag);
        int  cyc = 0, acc = 0, wcnt = 0, viol = 0;
        int  n_req = 0, n_we = 0, n_iord = 0, n_ir = 0, n_rw = 0, n_m2r = 0, n_pcw = 0, n_pct = 0;
        bit  done = 0, prev_wait = 0, is_mem, is_wb;
        int  exp_lat;
        bus.opcode = opcode_of(kind);
        bus.zero   = z;
        while (!done && cyc < 64) begin
            @(negedge clk);
            bus.mem_ready = bus.mem_req && (wcnt == ((acc == 0) ? fw : mw));
            #1;
            cyc++;
            if (prev_wait && !bus.mem_req) viol++;
            prev_wait = bus.mem_req && !bus.mem_ready;
            if (bus.mem_req) begin
                n_req++;
                if (bus.mem_ready) begin acc++; wcnt = 0; end
                else wcnt++;
            end
            n_we   += int'(bus.mem_we);
            n_iord += int'(bus.iord);
            n_ir   += int'(bus.ir_write);
            n_rw   += int'(bus.reg_write);
            n_m2r  += int'(bus.mem_2_reg);
            n_pcw  += int'(bus.pc_write);
            n_pct  += int'(bus.pc_write && bus.pc_src);
            if (cyc == 1)      check({tag, ".fetch"}, int'({bus.mem_req, bus.iord, bus.alu_src_a,
                                     bus.alu_src_b, bus.alu_op}), 8'b1_0_00_01_00);
            if (cyc == fw + 2) check({tag, ".decode"}, sel_vec(), 6'b00_10_00);
            if (cyc == fw + 3) check({tag, ".exec"}, sel_vec(), exec_sel(kind));
            if (bus.instr_done) done = 1;
        end
        is_mem  = (kind == K_LD) || (kind == K_ST);
        is_wb   = (kind == K_R) || (kind == K_I) || (kind == K_LD);
        exp_lat = fw + 1 + ((kind == K_R || kind == K_I) ? 3 :
                            (kind == K_LD) ? 4 + mw : (kind == K_ST) ? 3 + mw : 2);
        check({tag, ".done"},    int'(done), 1);
        check({tag, ".latency"}, cyc, exp_lat);
        check({tag, ".ir_wr"},   n_ir, 1);
        check({tag, ".reg_wr"},  n_rw, int'(is_wb));
        check({tag, ".mem2reg"}, n_m2r, int'(kind == K_LD));
        check({tag, ".pc_wr"},   n_pcw, 1 + int'(kind == K_BR && z) + int'(kind == K_JAL));
        check({tag, ".pc_tgt"},  n_pct, int'(kind == K_BR && z) + int'(kind == K_JAL));
        check({tag, ".mem_req"}, n_req, fw + 1 + (is_mem ? mw + 1 : 0));
        check({tag, ".mem_we"},  n_we, (kind == K_ST) ? mw + 1 : 0);
        check({tag, ".iord"},    n_iord, is_mem ? mw + 1 : 0);
        check({tag, ".hold"},    viol, 0);
    endtask

    initial begin
        int req_seen, done_seen, halt_low;
        rst = 1'b1;
        bus.opcode = 7'b0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset.outputs", out_vec(), 0);
        rst = 1'b0;

        // Directed: add, lw with 3 waits, beq taken / not taken, jal, store with waits.
        run_instr(K_R,   1'b0, 0, 0, "add");
        run_instr(K_LD,  1'b0, 0, 3, "lw3");
        run_instr(K_BR,  1'b1, 0, 0, "beq_t");
        run_instr(K_BR,  1'b0, 0, 0, "beq_nt");
        run_instr(K_JAL, 1'b0, 2, 0, "jal");
        run_instr(K_ST,  1'b1, 1, 2, "sw");

        // Illegal opcode: trap, stay silent and halted, then recover through reset.
        bus.opcode = 7'b1111111;
        @(negedge clk); bus.mem_ready = 1'b1; #1;
        check("trap.fetch_req", int'(bus.mem_req), 1);
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        check("trap.decode_halted", int'(bus.halted), 0);
        req_seen = 0; done_seen = 0; halt_low = 0;
        repeat (20) begin
            @(negedge clk); #1;
            req_seen  += int'(bus.mem_req);
            done_seen += int'(bus.instr_done);
            halt_low  += int'(!bus.halted);
        end
        check("trap.mem_req", req_seen, 0);
        check("trap.instr_done", done_seen, 0);
        check("trap.halted_low", halt_low, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        check("trap.reset_outputs", out_vec(), 0);
        rst = 1'b0;
        run_instr(K_I, 1'b0, 0, 0, "post_trap_addi");

        // Reset during a store's data wait abandons it.
        bus.opcode = opcode_of(K_ST);
        done_seen = 0;
        @(negedge clk); bus.mem_ready = 1'b1; #1; done_seen += int'(bus.instr_done);
        @(negedge clk); bus.mem_ready = 1'b0; #1; done_seen += int'(bus.instr_done);
        @(negedge clk); #1; done_seen += int'(bus.instr_done);
        @(negedge clk); #1; done_seen += int'(bus.instr_done);
        check("swrst.wait_req", int'({bus.mem_req, bus.mem_we, bus.iord}), 3'b111);
        @(negedge clk); rst = 1'b1; #1; done_seen += int'(bus.instr_done);
        @(negedge clk); #1; done_seen += int'(bus.instr_done);
        check("swrst.outputs", out_vec(), 0);
        check("swrst.no_done", done_seen, 0);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            run_instr(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  in  1  rising-edge clock; all state updates on this edge.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 opcode  in  7  instruction[6:0] from the instruction register; stable from DECODE until the instruction completes.
REQ-004 zero  in  1  ALU zero flag; sampled only in BRANCH.
REQ-005 mem_ready  in  1  memory handshake completion; qualifies mem_req in the same cycle.
REQ-006 mem_req  out  1  memory access request; held high until mem_ready is seen.
REQ-007 mem_we  out  1  write qualifier for mem_req.
REQ-008 iord  out  1  memory address select: 0 = PC, 1 = ALU-out register.
REQ-009 ir_write  out  1  load instruction register.
REQ-010 pc_write  out  1  update PC.
REQ-011 pc_src  out  1  next-PC select: 0 = PC+4, 1 = ALU-out (target).
REQ-012 alu_src_a  out  2  ALU A select: 00 = PC, 01 = rs1, 10 = zero.
REQ-013 alu_src_b  out  2  ALU B select: 00 = rs2, 01 = const 4, 10 = immediate.
REQ-014 alu_op  out  2  ALU operation class: 00 = add, 01 = sub, 10 = funct-decoded.
REQ-015 reg_write  out  1  register file write enable.
REQ-016 mem_2_reg  out  1  writeback select: 1 = memory data, 0 = ALU-out.
REQ-017 instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
REQ-018 halted  out  1  sticky flag set after an illegal opcode.

Function
REQ-019 The block SHALL be a Moore FSM with states IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP and TRAP, using a 4-bit encoding.
REQ-020 Any output not listed for a state SHALL be 0 in that state.
REQ-021 IDLE SHALL drive all outputs to 0 and SHALL go to FETCH on the next cycle.
REQ-022 FETCH SHALL assert mem_req with iord=0, alu_src_a=00, alu_src_b=01 and alu_op=00.
REQ-023 In FETCH, ir_write, pc_write (with pc_src=0) and the transition to DECODE SHALL occur only in the cycle where mem_ready=1; otherwise the FSM SHALL stay in FETCH.
REQ-024 DECODE SHALL drive alu_src_a=00, alu_src_b=10 and alu_op=00, precomputing the branch/jump target.
REQ-025 DECODE SHALL branch on opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 and 0100011 -> ADDR; 1100011 -> BRANCH; 1101111 -> JUMP; any other value -> TRAP.
REQ-026 EXEC_R SHALL drive alu_src_a=01, alu_src_b=00 and alu_op=10, then go to WB_ALU.
REQ-027 EXEC_I SHALL drive alu_src_a=01, alu_src_b=10 and alu_op=10, then go to WB_ALU.
REQ-028 ADDR SHALL drive alu_src_a=01, alu_src_b=10 and alu_op=00, then go to MEM_RD for a load or MEM_WR for a store.
REQ-029 MEM_RD SHALL assert mem_req with iord=1 and SHALL wait for mem_ready before going to WB_MEM.
REQ-030 MEM_WR SHALL assert mem_req and mem_we with iord=1, and on mem_ready SHALL pulse instr_done and go to FETCH.
REQ-031 WB_ALU SHALL assert reg_write with mem_2_reg=0; WB_MEM SHALL assert reg_write with mem_2_reg=1; both SHALL pulse instr_done and go to FETCH.
REQ-032 BRANCH SHALL drive alu_src_a=01, alu_src_b=00 and alu_op=01, set pc_write=zero with pc_src=1, pulse instr_done, and go to FETCH.
REQ-033 JUMP SHALL assert pc_write with pc_src=1, pulse instr_done, and go to FETCH.
REQ-034 TRAP SHALL set halted=1 and hold there until rst; it SHALL NOT pulse instr_done and SHALL NOT issue memory requests.
REQ-035 mem_req SHALL NOT drop while a FETCH/MEM_RD/MEM_WR is waiting, regardless of wait length, including 0 wait cycles.
REQ-036 Latency without wait states SHALL be: R/I-type 4 cycles, load 5, store 4, branch/jump 3 (FETCH through final state inclusive).

Reset
REQ-037 While rst=1 at a clock edge, the next state SHALL be IDLE and halted SHALL clear; all outputs SHALL be 0 the cycle after.
REQ-038 Reset asserted during an outstanding memory request SHALL abandon it: mem_req=0 from the next cycle, and no ir_write/reg_write SHALL occur for the aborted instruction.

Structure
REQ-039 Opcode values, ALUOp encodings, mux-select encodings and the state encoding SHALL live in the shared RISC-V package.
REQ-040 The state-to-outputs decode SHALL be one combinational sub-module, mc_out_decoder; next-state logic and the halted register SHALL stay in multicycle_control.

Verification
REQ-041 add (opcode 0110011), mem_ready=1 always -> states FETCH, DECODE, EXEC_R, WB_ALU; reg_write=1 in cycle 4; one instr_done pulse.
REQ-042 lw (0000011), data memory ready after 3 wait cycles -> mem_req held 4 cycles in MEM_RD; reg_write with mem_2_reg=1 one cycle later; total 8 cycles.
REQ-043 beq (1100011), zero=1 then zero=0 -> pc_write=1 with pc_src=1 in the first case; pc_write=0 in the second; both take 3 cycles.
REQ-044 opcode 1111111 -> TRAP, halted=1, mem_req stays 0 for 20 cycles; rst pulse -> IDLE then FETCH, halted=0.
REQ-045 rst asserted in a MEM_WR wait cycle -> next cycle mem_req=0, mem_we=0, state IDLE; no instr_done pulse.
